// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sign-magnitude sequential divider.
//   DEF_MAG_W  : default magnitude width used by the divider
//   CNT_W      : iteration counter width for the default magnitude width
//   state_t    : divider FSM states (IDLE, CALC, DONE)
//   sign_norm  : clears the sign bit of a zero magnitude so no -0 is produced
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DEF_MAG_W = 2;
    localparam int CNT_W     = $clog2(DEF_MAG_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // A zero magnitude always carries a positive sign.
    function automatic logic sign_norm(input logic sign, input logic mag_is_zero);
        return sign & ~mag_is_zero;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_in   : partial remainder before this step
//   bit_in   : next dividend bit (shifted in from the right)
//   divisor  : divisor magnitude
//   rem_out  : partial remainder after this step
//   q_bit    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int MAG_W = 2
) (
    input  logic [MAG_W-1:0] rem_in,
    input  logic             bit_in,
    input  logic [MAG_W-1:0] divisor,
    output logic [MAG_W-1:0] rem_out,
    output logic             q_bit
);

    logic [MAG_W:0]   shifted;
    logic [MAG_W+1:0] diff;

    // Shift the next dividend bit in and trial-subtract the divisor. The extra
    // top bit of diff is the borrow: when clear the difference is kept and the
    // quotient bit is 1, otherwise the shifted value is restored. Either result
    // is smaller than the divisor, so it always fits back into MAG_W bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        q_bit   = ~diff[MAG_W+1];
        rem_out = MAG_W'(q_bit ? diff : {1'b0, shifted});
    end

endmodule

// File: rtl/sm_seq_divider.sv
// -----------------------------------------------------------------------------
// sm_seq_divider
// Iterative sign-magnitude restoring divider, one quotient bit per clock.
// Operands/results are MAG_W+1 bits: MSB = sign (1 = negative), rest = magnitude.
// MAG_W must be at least 2.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_start  : request, sampled only while idle
//   i_A/i_B  : dividend / divisor
//   o_busy   : high whenever the FSM is not idle
//   o_done   : one-cycle pulse, results valid from this cycle
//   o_quot   : quotient, truncated toward zero
//   o_rem    : remainder, carries the dividend sign
//   o_Z      : quotient magnitude is zero
//   o_DZ     : divide by zero (divisor magnitude zero)
// Optional feature macro: DIV_EARLY_TERM_EN -- when defined, |A| < |B| with a
// non-zero divisor skips the iterations and finishes straight away.
// -----------------------------------------------------------------------------
module sm_seq_divider
    import div_pkg::*;
#(
    parameter int MAG_W = DEF_MAG_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [MAG_W:0]   i_A,
    input  logic [MAG_W:0]   i_B,
    output logic             o_busy,
    output logic             o_done,
    output logic [MAG_W:0]   o_quot,
    output logic [MAG_W:0]   o_rem,
    output logic             o_Z,
    output logic             o_DZ
);

    localparam int CNT_BITS = $clog2(MAG_W + 1);

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic [MAG_W-1:0]    a_mag;
    logic [MAG_W-1:0]    b_mag;
    logic                a_sign;
    logic                b_sign;
    logic [MAG_W-1:0]    prem;
    logic [MAG_W-1:0]    qbits;
    logic                dz_flag;
    logic                skip;

    logic [MAG_W-1:0]    step_rem;
    logic                step_q;
    logic [MAG_W-1:0]    a_in_mag;
    logic [MAG_W-1:0]    b_in_mag;

    assign a_in_mag = i_A[MAG_W-1:0];
    assign b_in_mag = i_B[MAG_W-1:0];

    // The dividend is consumed MSB first from the top of the a_mag shifter.
    div_step #(
        .MAG_W(MAG_W)
    ) u_step (
        .rem_in (prem),
        .bit_in (a_mag[MAG_W-1]),
        .divisor(b_mag),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    // Main FSM with registered outputs. The shortcut routes (divide by zero and
    // the optional early termination) preload the quotient/remainder registers
    // with their final values so that DONE publishes every result the same way.
    // Those routes linger one extra cycle in DONE (skip) so their done pulse
    // lands two edges after the accepting edge; the normal route arrives in
    // DONE on its last iteration and pulses on the following edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_mag   <= '0;
            b_mag   <= '0;
            a_sign  <= 1'b0;
            b_sign  <= 1'b0;
            prem    <= '0;
            qbits   <= '0;
            dz_flag <= 1'b0;
            skip    <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_quot  <= '0;
            o_rem   <= '0;
            o_Z     <= 1'b0;
            o_DZ    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_sign <= i_A[MAG_W];
                        b_sign <= i_B[MAG_W];
                        b_mag  <= b_in_mag;
                        a_mag  <= a_in_mag;
                        o_busy <= 1'b1;
                        o_DZ   <= 1'b0;
                        if (b_in_mag == '0) begin
                            dz_flag <= 1'b1;
                            skip    <= 1'b1;
                            prem    <= a_in_mag;
                            qbits   <= '1;
                            state   <= DONE;
                        end
`ifdef DIV_EARLY_TERM_EN
                        else if (a_in_mag < b_in_mag) begin
                            dz_flag <= 1'b0;
                            skip    <= 1'b1;
                            prem    <= a_in_mag;
                            qbits   <= '0;
                            state   <= DONE;
                        end
`endif
                        else begin
                            dz_flag <= 1'b0;
                            skip    <= 1'b0;
                            prem    <= '0;
                            qbits   <= '0;
                            cnt     <= CNT_BITS'(MAG_W - 1);
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem  <= step_rem;
                    qbits <= {qbits[MAG_W-2:0], step_q};
                    a_mag <= a_mag << 1;
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_BITS'(1);
                    end
                end
                DONE: begin
                    if (skip) begin
                        skip <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_quot <= {sign_norm(a_sign ^ b_sign, qbits == '0), qbits};
                        o_rem  <= {sign_norm(a_sign, prem == '0), prem};
                        o_Z    <= (qbits == '0);
                        o_DZ   <= dz_flag;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_sm_seq_divider
// Directed testbench for sm_seq_divider (MAG_W = 2) with an arithmetic
// reference model compared against the DUT on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_sm_seq_divider;

    localparam int W = 2;

`ifdef DIV_EARLY_TERM_EN
    localparam int SMALL_LAT = 2;
`else
    localparam int SMALL_LAT = W + 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W:0]   a;
    logic [W:0]   b;
    logic         busy;
    logic         done;
    logic [W:0]   quot;
    logic [W:0]   rem;
    logic         z_flag;
    logic         dz_flag;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [W:0] m_quot = '0;
    logic [W:0] m_rem  = '0;
    logic       m_z    = 1'b0;
    logic       m_dz   = 1'b0;
    int         m_left = 0;
    logic [W:0] p_quot;
    logic [W:0] p_rem;
    logic       p_z;
    logic       p_dz;

    sm_seq_divider #(
        .MAG_W(W)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_A    (a),
        .i_B    (b),
        .o_busy (busy),
        .o_done (done),
        .o_quot (quot),
        .o_rem  (rem),
        .o_Z    (z_flag),
        .o_DZ   (dz_flag)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks_total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end else begin
            checks_passed++;
        end
    endtask

    // Reference model: works purely from the arithmetic meaning of the
    // operation. On an accepted start it computes the final results with
    // integer divide/modulo and the expected latency, then releases them
    // (with a done pulse) once that many edges have passed.
    always @(posedge clk or negedge rst_n) begin
        int am, bm, qm, rm, lat;
        logic as, bs;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_quot = '0;
            m_rem  = '0;
            m_z    = 1'b0;
            m_dz   = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    as = a[W];
                    bs = b[W];
                    am = int'(a[W-1:0]);
                    bm = int'(b[W-1:0]);
                    if (bm == 0) begin
                        p_quot = {as ^ bs, {W{1'b1}}};
                        p_rem  = {as && (am != 0), W'(am)};
                        p_z    = 1'b0;
                        p_dz   = 1'b1;
                        lat    = 2;
                    end else begin
                        qm     = am / bm;
                        rm     = am % bm;
                        p_quot = {(as ^ bs) && (qm != 0), W'(qm)};
                        p_rem  = {as && (rm != 0), W'(rm)};
                        p_z    = (qm == 0);
                        p_dz   = 1'b0;
                        lat    = (am < bm) ? SMALL_LAT : W + 1;
                    end
                    m_dz   = 1'b0;
                    m_busy = 1'b1;
                    m_left = lat;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_quot = p_quot;
                    m_rem  = p_rem;
                    m_z    = p_z;
                    m_dz   = p_dz;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every DUT output against the model,
    // sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        check("cyc_busy", busy,    m_busy);
        check("cyc_done", done,    m_done);
        check("cyc_quot", quot,    m_quot);
        check("cyc_rem",  rem,     m_rem);
        check("cyc_z",    z_flag,  m_z);
        check("cyc_dz",   dz_flag, m_dz);
    end

    // Issue one start and count edges until the done pulse (bounded).
    // With inject set, a second start with different operands is pulsed
    // while the divider is busy.
    task automatic applyStimulus(input logic [W:0] av, input logic [W:0] bv,
                                 input logic inject, output int edges);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (inject) begin
            a     = 3'b111;
            b     = 3'b110;
            start = 1'b1;
        end else begin
            start = 1'b0;
            a     = ~av;
            b     = ~bv;
        end
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            if (done) break;
        end
    endtask

    // Compare the latched results and latency against hand-computed values.
    task automatic checkOutput(input string name, input int edges, input int lat,
                               input logic [W:0] q, input logic [W:0] r,
                               input logic z, input logic dz);
        checks_total++;
        if (edges != lat) begin
            $display("[TB] FAIL %s_latency: got %0d edges, expected %0d", name, edges, lat);
        end else begin
            checks_passed++;
        end
        check({name, "_quot"}, quot,    q);
        check({name, "_rem"},  rem,     r);
        check({name, "_z"},    z_flag,  z);
        check({name, "_dz"},   dz_flag, dz);
    endtask

    initial begin
        int edges;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_quot", quot, 3'b000);
        check("reset_rem",  rem,  3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // +3 / -1
        applyStimulus(3'b011, 3'b101, 1'b0, edges);
        checkOutput("t1", edges, 3, 3'b111, 3'b000, 1'b0, 1'b0);

        // -3 / -2
        applyStimulus(3'b111, 3'b110, 1'b0, edges);
        checkOutput("t2", edges, 3, 3'b001, 3'b101, 1'b0, 1'b0);

        // -2 / +3: zero quotient with forced positive sign
        applyStimulus(3'b110, 3'b011, 1'b0, edges);
        checkOutput("t3", edges, SMALL_LAT, 3'b000, 3'b110, 1'b1, 1'b0);

        // +3 / -0: divide by zero
        applyStimulus(3'b011, 3'b100, 1'b0, edges);
        checkOutput("t4", edges, 2, 3'b111, 3'b011, 1'b0, 1'b1);

        // -2 / +0: divide by zero, negative dividend
        applyStimulus(3'b110, 3'b000, 1'b0, edges);
        checkOutput("t4b", edges, 2, 3'b111, 3'b110, 1'b0, 1'b1);

        // +2 / +1 with a start pulsed during CALC: must be ignored
        applyStimulus(3'b010, 3'b001, 1'b1, edges);
        checkOutput("t5", edges, 3, 3'b010, 3'b000, 1'b0, 1'b0);
        // a start back in IDLE is accepted again
        applyStimulus(3'b011, 3'b010, 1'b0, edges);
        checkOutput("t5b", edges, 3, 3'b001, 3'b001, 1'b0, 1'b0);

        // -1 / +2 and -0 / +1: remainder sign, no -0 outputs
        applyStimulus(3'b101, 3'b010, 1'b0, edges);
        checkOutput("t7", edges, SMALL_LAT, 3'b000, 3'b101, 1'b1, 1'b0);
        applyStimulus(3'b100, 3'b001, 1'b0, edges);
        checkOutput("t8", edges, SMALL_LAT, 3'b000, 3'b000, 1'b1, 1'b0);

        // Reset in the middle of CALC: outputs clear at once, no done pulse
        @(negedge clk);
        a     = 3'b011;
        b     = 3'b001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_quot", quot, 3'b000);
        check("t6_rem",  rem,  3'b000);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("t6_nodone", done, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3'b011, 3'b101, 1'b0, edges);
        checkOutput("t6_after", edges, 3, 3'b111, 3'b000, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
